// File: rtl/br_multiport_pkg.sv
// Shared definitions for the multiport register bank: clear-sequencer state
// encodings and default parameter values (also used by the hazard unit).
package br_multiport_pkg;

  typedef logic [0:0] br_state_t;

  localparam br_state_t BR_IDLE  = 1'b0;
  localparam br_state_t BR_CLEAR = 1'b1;

  localparam int BR_XLEN_DEF     = 32;
  localparam int BR_NREG_DEF     = 32;
  localparam int BR_NRD_DEF      = 2;
  localparam int BR_ZERO_REG_DEF = 1;
  localparam int BR_BYPASS_DEF   = 1;

endpackage

// File: rtl/br_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by a reserve (load
// issue), cleared by a retiring write, wiped when a clear sweep starts.
module br_scoreboard
  import br_multiport_pkg::*;
#(
  parameter int NREG     = BR_NREG_DEF,
  parameter int NRD      = BR_NRD_DEF,
  parameter int ZERO_REG = BR_ZERO_REG_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rsv_en_i,
  input  logic [$clog2(NREG)-1:0]      rsv_a_i,
  input  logic                         ret_en_i,
  input  logic [$clog2(NREG)-1:0]      ret_a_i,
  input  logic                         flush_i,
  input  logic [NRD*$clog2(NREG)-1:0]  ra_i,
  input  logic [NRD-1:0]               hit_i,
  output logic [NRD-1:0]               pend_o
);
  localparam int AW = $clog2(NREG);

  logic [NREG-1:0] p_q, p_d;

  // Next pending vector: retire first so a same-address reserve wins.
  always_comb begin
    p_d = p_q;
    if (ret_en_i) p_d[ret_a_i] = 1'b0;
    if (rsv_en_i) p_d[rsv_a_i] = 1'b1;
    if (flush_i)  p_d = '0;
    if (ZERO_REG != 0) p_d[0] = 1'b0;
  end

  // Pending bits register.
  always_ff @(posedge clk_i) begin
    if (rst_i) p_q <= '0;
    else       p_q <= p_d;
  end

  // A bypassed write already delivers the data, so the read is not pending.
  for (genvar g = 0; g < NRD; g++) begin : g_pend
    assign pend_o[g] = p_q[ra_i[g*AW +: AW]] & ~hit_i[g];
  end

endmodule

// File: rtl/br_multiport.sv
// Multiport register bank: NRD combinational read ports with optional
// write bypass, one synchronous write port, hardwired zero register,
// pending scoreboard and a one-register-per-cycle background clear sweep.
module br_multiport
  import br_multiport_pkg::*;
#(
  parameter int XLEN     = BR_XLEN_DEF,
  parameter int NREG     = BR_NREG_DEF,
  parameter int NRD      = BR_NRD_DEF,
  parameter int ZERO_REG = BR_ZERO_REG_DEF,
  parameter int BYPASS   = BR_BYPASS_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NRD*$clog2(NREG)-1:0]  ra_i,
  output logic [NRD*XLEN-1:0]          rd_o,
  output logic [NRD-1:0]               pend_o,
  input  logic [$clog2(NREG)-1:0]      wa_i,
  input  logic [XLEN-1:0]              wd_i,
  input  logic                         we_i,
  input  logic                         rsv_en_i,
  input  logic [$clog2(NREG)-1:0]      rsv_a_i,
  input  logic                         clr_i,
  output logic                         busy_o
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] mem_q [NREG];
  br_state_t       state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            clr_start;
  logic            wr_ok;
  logic [NRD-1:0]  hit;

  // Writes to the hardwired zero register are dropped entirely.
  assign wr_ok  = we_i && !((ZERO_REG != 0) && (wa_i == '0));
  assign busy_o = (state_q == BR_CLEAR);

  // Clear sequencer next state: sweep idx 0..NREG-1, clr ignored while busy.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    clr_start = 1'b0;
    case (state_q)
      BR_IDLE: begin
        if (clr_i) begin
          state_d   = BR_CLEAR;
          idx_d     = '0;
          clr_start = 1'b1;
        end
      end
      BR_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (&idx_q) state_d = BR_IDLE;
      end
      default: state_d = BR_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BR_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Storage: the external write is issued after the sweep zero so it wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      if (state_q == BR_CLEAR) mem_q[idx_q] <= '0;
      if (wr_ok)               mem_q[wa_i]  <= wd_i;
    end
  end

  // Read ports with zero-register and same-cycle bypass handling.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic          zr;
    assign a      = ra_i[g*AW +: AW];
    assign zr     = (ZERO_REG != 0) && (a == '0);
    assign hit[g] = (BYPASS != 0) && wr_ok && (wa_i == a);
    assign rd_o[g*XLEN +: XLEN] = zr ? '0 : (hit[g] ? wd_i : mem_q[a]);
  end

  br_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rsv_en_i (rsv_en_i),
    .rsv_a_i  (rsv_a_i),
    .ret_en_i (we_i),
    .ret_a_i  (wa_i),
    .flush_i  (clr_start),
    .ra_i     (ra_i),
    .hit_i    (hit),
    .pend_o   (pend_o)
  );

endmodule
